id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Registers one decoded instruction and drives the ALU's data1, data2 and ALUControl inputs.
- Resolves EX/MEM and MEM/WB forwarding and load-use hazards.
- Uses a valid/ready handshake toward decode and toward EX.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register address width
CTRL_W, 4, ALU control width (ADD=0000, SUB=0001, MUL=0010)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous squash of held/incoming instruction
in_valid  input  1  decode offers instruction
in_ready  output  1  stage accepts instruction this cycle
in_rs_data, in_rt_data  input  DATA_W  register-file read values
in_imm  input  DATA_W  sign-extended immediate
in_rs_addr, in_rt_addr, in_rd_addr  input  REG_ADDR_W  source/dest registers
in_alu_op  input  CTRL_W  ALU operation
in_use_imm  input  1  data2 takes immediate instead of rt
in_reg_write  input  1  instruction writes rd
exmem_reg_write, exmem_mem_read  input  1  EX/MEM writer / is load
exmem_rd_addr  input  REG_ADDR_W  EX/MEM destination
exmem_result  input  DATA_W  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writer
memwb_rd_addr  input  REG_ADDR_W  MEM/WB destination
memwb_data  input  DATA_W  MEM/WB writeback value
out_valid  output  1  data1/data2/ALUControl valid for EX
out_ready  input  1  EX consumes this cycle
data1, data2  output  DATA_W  forwarded ALU operands
ALUControl  output  CTRL_W  registered in_alu_op
out_rd_addr  output  REG_ADDR_W  registered in_rd_addr
out_reg_write  output  1  registered in_reg_write, forced 0 when out_valid=0
bubble_count  output  8  saturating count of load-use bubble cycles

Behaviour:
- Reset (reset=0 at clk edge):
  - state=EMPTY.
  - All stored fields, data1, data2, ALUControl, out_rd_addr, out_reg_write and bubble_count = 0.
  - out_valid=0, in_ready=1 after reset.
  - Reset has priority over flush and capture.
- States:
  - EMPTY: no instruction held.
  - FULL: instruction held.
- lu_hazard (combinational): FULL && exmem_mem_read && exmem_reg_write && exmem_rd_addr!=0 && (exmem_rd_addr==rs || (!use_imm && exmem_rd_addr==rt)).
- out_valid = FULL && !lu_hazard.
- in_ready = EMPTY || (out_valid && out_ready).
- Capture: in_valid && in_ready → FULL next cycle; new fields registered; latency 1 cycle.
- Consume without capture: out_valid && out_ready && !in_valid → EMPTY.
- Stall (FULL, !in_ready): all stored fields held. Exception — refresh: if memwb_reg_write && memwb_rd_addr!=0 matches stored rs/rt, the stored operand is overwritten with memwb_data, so the value survives the writer retiring.
- Forwarding (combinational on stored operands), per source:
  - EX/MEM match (reg_write, addr!=0, !mem_read) → exmem_result.
  - Else MEM/WB match → memwb_data.
  - Else stored value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- data2 = stored imm when use_imm; no rt forwarding then.
- bubble_count increments each cycle lu_hazard=1, saturating at 255.
- Flush: EMPTY next cycle, incoming in_valid dropped, out_reg_write=0. bubble_count not cleared.
- Reset mid-stall discards the held instruction.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined:
  - Captured in_alu_op outside {0000,0001,0010} sets sticky output illegal_op (1 bit, cleared only by reset).
  - The instruction is captured as a bubble: out_valid=0, state EMPTY.
- Undefined: op passes through unchanged; no illegal_op port.

Test Plan:
1. reset=0 two cycles, then 1 → out_valid=0, data1=data2=0, ALUControl=0, bubble_count=0, in_ready=1.
2. Capture rs_data=5, rt_data=7, op=0000, out_ready=1 → next cycle out_valid=1, data1=5, data2=7, ALUControl=0000; use_imm=1, imm=0xFFFFFFFC → data2=0xFFFFFFFC.
3. Forward priority, rs=3:
   - exmem rd=3 result=0x10 and memwb rd=3 data=0x20 → data1=0x10.
   - exmem rd=0 → data1=0x20.
4. Load-use on rt=4 (exmem_mem_read=1, rd=4) → out_valid=0, in_ready=0, bubble_count=1. Next cycle memwb rd=4 data=0x55 → out_valid=1, data2=0x55.
5. out_ready=0 for 3 cycles → outputs stable, in_ready=0. Flush with in_valid=1 same cycle → EMPTY next cycle, out_valid=0.
6. With ILLEGAL_OP_TRAP_EN, capture op=0111 → illegal_op=1, out_valid=0; stays 1 until reset.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register that sits directly in front of the ALU. Holds one
//   decoded instruction and presents forwarded operands (data1/data2) and the
//   ALU operation (ALUControl) to EX. It resolves EX/MEM and MEM/WB
//   forwarding and stalls on load-use hazards.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both 1. valid never depends on ready on the same side.
//   Upstream: in_valid/in_ready. Downstream: out_valid/out_ready.
//
// Ports:
//   clk, reset (sync, active-low), flush (sync squash)
//   in_valid/in_ready           decode-side handshake
//   in_rs_data/in_rt_data/in_imm, in_rs_addr/in_rt_addr/in_rd_addr,
//   in_alu_op/in_use_imm/in_reg_write  decoded instruction fields
//   exmem_* / memwb_*           downstream writers used for forwarding/hazards
//   out_valid/out_ready         EX-side handshake
//   data1/data2/ALUControl      ALU inputs
//   out_rd_addr/out_reg_write   destination info passed to EX
//   bubble_count                saturating count of load-use bubble cycles
//   illegal_op                  sticky trap flag (only with ILLEGAL_OP_TRAP_EN)
//   dbg_state                   FSM state (0 = EMPTY, 1 = FULL)
//
// Build option: define ILLEGAL_OP_TRAP_EN to turn unknown ALU ops into
//   bubbles and raise the sticky illegal_op output.
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_rs_data,
    input  logic [DATA_W-1:0]     in_rt_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [REG_ADDR_W-1:0] in_rs_addr,
    input  logic [REG_ADDR_W-1:0] in_rt_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [CTRL_W-1:0]     in_alu_op,
    input  logic                  in_use_imm,
    input  logic                  in_reg_write,
    input  logic                  exmem_reg_write,
    input  logic                  exmem_mem_read,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]     memwb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     data1,
    output logic [DATA_W-1:0]     data2,
    output logic [CTRL_W-1:0]     ALUControl,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic                  illegal_op,
`endif
    output logic [7:0]            bubble_count,
    output logic                  dbg_state
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_imm;
    logic [REG_ADDR_W-1:0] r_rs_addr;
    logic [REG_ADDR_W-1:0] r_rt_addr;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [CTRL_W-1:0]     r_alu_op;
    logic                  r_use_imm;
    logic                  r_reg_write;
    logic [7:0]            r_bubble_count;

    logic                  w_full;
    logic                  w_lu_hazard;
    logic                  w_out_valid;
    logic                  w_in_ready;
    logic                  w_capture;
    logic                  w_op_legal;
    logic                  w_exmem_fwd_ok;
    logic                  w_memwb_fwd_ok;
    logic                  w_refresh_rs;
    logic                  w_refresh_rt;
    logic [DATA_W-1:0]     w_rs_fwd;
    logic [DATA_W-1:0]     w_rt_fwd;

    // ------------------------------------------------------------------
    // Handshake and hazard detection
    // ------------------------------------------------------------------
    assign w_full = (r_state == S_FULL);

    // A load in EX/MEM cannot be forwarded yet; rt only matters when the
    // immediate is not replacing it.
    assign w_lu_hazard = w_full && exmem_mem_read && exmem_reg_write &&
                         (exmem_rd_addr != '0) &&
                         ((exmem_rd_addr == r_rs_addr) ||
                          (!r_use_imm && (exmem_rd_addr == r_rt_addr)));

    assign w_out_valid = w_full && !w_lu_hazard;
    assign w_in_ready  = !w_full || (w_out_valid && out_ready);
    assign w_capture   = in_valid && w_in_ready && !flush;

`ifdef ILLEGAL_OP_TRAP_EN
    assign w_op_legal = (in_alu_op == CTRL_W'(0)) ||
                        (in_alu_op == CTRL_W'(1)) ||
                        (in_alu_op == CTRL_W'(2));
`else
    assign w_op_legal = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else if (w_capture) begin
            // An illegal op (trap build only) is taken off decode but held
            // as a bubble.
            w_state_next = w_op_legal ? S_FULL : S_EMPTY;
        end else if (w_out_valid && out_ready) begin
            w_state_next = S_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding (EX/MEM beats MEM/WB; register 0 never forwarded)
    // ------------------------------------------------------------------
    assign w_exmem_fwd_ok = exmem_reg_write && !exmem_mem_read && (exmem_rd_addr != '0);
    assign w_memwb_fwd_ok = memwb_reg_write && (memwb_rd_addr != '0);

    always_comb begin
        w_rs_fwd = r_rs_data;
        if (w_exmem_fwd_ok && (exmem_rd_addr == r_rs_addr)) begin
            w_rs_fwd = exmem_result;
        end else if (w_memwb_fwd_ok && (memwb_rd_addr == r_rs_addr)) begin
            w_rs_fwd = memwb_data;
        end
    end

    always_comb begin
        w_rt_fwd = r_rt_data;
        if (w_exmem_fwd_ok && (exmem_rd_addr == r_rt_addr)) begin
            w_rt_fwd = exmem_result;
        end else if (w_memwb_fwd_ok && (memwb_rd_addr == r_rt_addr)) begin
            w_rt_fwd = memwb_data;
        end
    end

    // While an instruction sits here, a retiring MEM/WB writer would take its
    // value with it; copy it into the stored operand so it is not lost.
    assign w_refresh_rs = w_full && !w_capture && w_memwb_fwd_ok && (memwb_rd_addr == r_rs_addr);
    assign w_refresh_rt = w_full && !w_capture && w_memwb_fwd_ok && (memwb_rd_addr == r_rt_addr);

    // ------------------------------------------------------------------
    // Stored instruction fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_alu_op    <= '0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (w_capture) begin
            r_rs_data   <= in_rs_data;
            r_rt_data   <= in_rt_data;
            r_imm       <= in_imm;
            r_rs_addr   <= in_rs_addr;
            r_rt_addr   <= in_rt_addr;
            r_rd_addr   <= in_rd_addr;
            r_alu_op    <= in_alu_op;
            r_use_imm   <= in_use_imm;
            r_reg_write <= in_reg_write;
        end else begin
            if (w_refresh_rs) begin
                r_rs_data <= memwb_data;
            end
            if (w_refresh_rt) begin
                r_rt_data <= memwb_data;
            end
        end
    end

    // Saturating load-use bubble counter; flush does not clear it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_count <= 8'd0;
        end else if (w_lu_hazard && (r_bubble_count != 8'hFF)) begin
            r_bubble_count <= r_bubble_count + 8'd1;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal_op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_illegal_op <= 1'b0;
        end else if (w_capture && !w_op_legal) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign illegal_op = r_illegal_op;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign data1         = w_rs_fwd;
    assign data2         = r_use_imm ? r_imm : w_rt_fwd;
    assign ALUControl    = r_alu_op;
    assign out_rd_addr   = r_rd_addr;
    assign out_reg_write = r_reg_write && w_out_valid;
    assign bubble_count  = r_bubble_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed self-checking bench for id_ex_stage. Inputs are driven just
//   after the falling edge; outputs are compared away from the rising edge.
//   Define ILLEGAL_OP_TRAP_EN for both RTL and bench to cover the trap.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 4;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_rs_data;
    logic [DATA_W-1:0]     in_rt_data;
    logic [DATA_W-1:0]     in_imm;
    logic [REG_ADDR_W-1:0] in_rs_addr;
    logic [REG_ADDR_W-1:0] in_rt_addr;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic [CTRL_W-1:0]     in_alu_op;
    logic                  in_use_imm;
    logic                  in_reg_write;
    logic                  exmem_reg_write;
    logic                  exmem_mem_read;
    logic [REG_ADDR_W-1:0] exmem_rd_addr;
    logic [DATA_W-1:0]     exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd_addr;
    logic [DATA_W-1:0]     memwb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic [CTRL_W-1:0]     ALUControl;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_write;
    logic [7:0]            bubble_count;
    logic                  dbg_state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic                  illegal_op;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .CTRL_W    (CTRL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs_data     (in_rs_data),
        .in_rt_data     (in_rt_data),
        .in_imm         (in_imm),
        .in_rs_addr     (in_rs_addr),
        .in_rt_addr     (in_rt_addr),
        .in_rd_addr     (in_rd_addr),
        .in_alu_op      (in_alu_op),
        .in_use_imm     (in_use_imm),
        .in_reg_write   (in_reg_write),
        .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read (exmem_mem_read),
        .exmem_rd_addr  (exmem_rd_addr),
        .exmem_result   (exmem_result),
        .memwb_reg_write(memwb_reg_write),
        .memwb_rd_addr  (memwb_rd_addr),
        .memwb_data     (memwb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data1          (data1),
        .data2          (data2),
        .ALUControl     (ALUControl),
        .out_rd_addr    (out_rd_addr),
        .out_reg_write  (out_reg_write),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op     (illegal_op),
`endif
        .bubble_count   (bubble_count),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // One full cycle: the rising edge samples the current inputs, then return
    // shortly after the falling edge so new inputs can be applied.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_fwd();
        exmem_reg_write = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_rd_addr   = '0;
        exmem_result    = '0;
        memwb_reg_write = 1'b0;
        memwb_rd_addr   = '0;
        memwb_data      = '0;
    endtask

    task automatic drive_instr(input logic [DATA_W-1:0] rs_d, input logic [DATA_W-1:0] rt_d,
                               input logic [DATA_W-1:0] imm, input logic [REG_ADDR_W-1:0] rs_a,
                               input logic [REG_ADDR_W-1:0] rt_a, input logic [REG_ADDR_W-1:0] rd_a,
                               input logic [CTRL_W-1:0] op, input logic use_imm, input logic reg_wr);
        in_valid     = 1'b1;
        in_rs_data   = rs_d;
        in_rt_data   = rt_d;
        in_imm       = imm;
        in_rs_addr   = rs_a;
        in_rt_addr   = rt_a;
        in_rd_addr   = rd_a;
        in_alu_op    = op;
        in_use_imm   = use_imm;
        in_reg_write = reg_wr;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_checks++; if (data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1 got=%h exp=0", data1); end
        n_checks++; if (data2 !== 32'h0) begin n_fail++; $display("FAIL reset_data2 got=%h exp=0", data2); end
        n_checks++; if (ALUControl !== 4'h0) begin n_fail++; $display("FAIL reset_alucontrol got=%h exp=0", ALUControl); end
        n_checks++; if (bubble_count !== 8'd0) begin n_fail++; $display("FAIL reset_bubble got=%0d exp=0", bubble_count); end
        n_checks++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_out_reg_write got=%0b exp=0", out_reg_write); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
    endtask

    task automatic test_capture();
        out_ready = 1'b1;
        drive_instr(32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd5, 4'b0000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cap_out_valid got=%0b exp=1", out_valid); end
        n_checks++; if (data1 !== 32'd5) begin n_fail++; $display("FAIL cap_data1 got=%h exp=5", data1); end
        n_checks++; if (data2 !== 32'd7) begin n_fail++; $display("FAIL cap_data2 got=%h exp=7", data2); end
        n_checks++; if (ALUControl !== 4'b0000) begin n_fail++; $display("FAIL cap_alucontrol got=%h exp=0", ALUControl); end
        n_checks++; if (out_rd_addr !== 5'd5) begin n_fail++; $display("FAIL cap_rd got=%0d exp=5", out_rd_addr); end
        n_checks++; if (out_reg_write !== 1'b1) begin n_fail++; $display("FAIL cap_reg_write got=%0b exp=1", out_reg_write); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_in_ready got=%0b exp=1", in_ready); end
        // Immediate replaces rt.
        drive_instr(32'd5, 32'd7, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd5, 4'b0000, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (data2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_data2 got=%h exp=fffffffc", data2); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL imm_out_valid got=%0b exp=1", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL drain_reg_write got=%0b exp=0", out_reg_write); end
    endtask

    task automatic test_forward_priority();
        out_ready = 1'b1;
        drive_instr(32'h1, 32'h2, 32'h0, 5'd3, 5'd2, 5'd4, 4'b0000, 1'b0, 1'b1);
        tick();
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        exmem_reg_write = 1'b1;
        exmem_rd_addr   = 5'd3;
        exmem_result    = 32'h10;
        memwb_reg_write = 1'b1;
        memwb_rd_addr   = 5'd3;
        memwb_data      = 32'h20;
        #1;
        n_checks++; if (data1 !== 32'h10) begin n_fail++; $display("FAIL fwd_exmem_prio got=%h exp=10", data1); end
        n_checks++; if (data2 !== 32'h2) begin n_fail++; $display("FAIL fwd_rt_untouched got=%h exp=2", data2); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fwd_in_ready got=%0b exp=0", in_ready); end
        exmem_rd_addr = 5'd0;
        #1;
        n_checks++; if (data1 !== 32'h20) begin n_fail++; $display("FAIL fwd_memwb got=%h exp=20", data1); end
        idle_fwd();
        #1;
        n_checks++; if (data1 !== 32'h1) begin n_fail++; $display("FAIL fwd_none got=%h exp=1", data1); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reg0();
        out_ready = 1'b1;
        drive_instr(32'h77, 32'h88, 32'h0, 5'd0, 5'd0, 5'd1, 4'b0000, 1'b0, 1'b1);
        tick();
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        exmem_reg_write = 1'b1;
        exmem_mem_read  = 1'b1;
        exmem_rd_addr   = 5'd0;
        exmem_result    = 32'h10;
        memwb_reg_write = 1'b1;
        memwb_rd_addr   = 5'd0;
        memwb_data      = 32'h20;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL r0_no_hazard got=%0b exp=1", out_valid); end
        n_checks++; if (data1 !== 32'h77) begin n_fail++; $display("FAIL r0_data1 got=%h exp=77", data1); end
        n_checks++; if (data2 !== 32'h88) begin n_fail++; $display("FAIL r0_data2 got=%h exp=88", data2); end
        idle_fwd();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        drive_instr(32'hA, 32'h3, 32'h0, 5'd1, 5'd4, 5'd6, 4'b0001, 1'b0, 1'b1);
        tick();
        in_valid        = 1'b0;
        exmem_reg_write = 1'b1;
        exmem_mem_read  = 1'b1;
        exmem_rd_addr   = 5'd4;
        exmem_result    = 32'hBAD;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_in_ready got=%0b exp=0", in_ready); end
        n_checks++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL lu_reg_write got=%0b exp=0", out_reg_write); end
        tick();
        idle_fwd();
        memwb_reg_write = 1'b1;
        memwb_rd_addr   = 5'd4;
        memwb_data      = 32'h55;
        #1;
        n_checks++; if (bubble_count !== 8'd1) begin n_fail++; $display("FAIL lu_bubble got=%0d exp=1", bubble_count); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_resolved got=%0b exp=1", out_valid); end
        n_checks++; if (data2 !== 32'h55) begin n_fail++; $display("FAIL lu_data2 got=%h exp=55", data2); end
        n_checks++; if (data1 !== 32'hA) begin n_fail++; $display("FAIL lu_data1 got=%h exp=a", data1); end
        n_checks++; if (ALUControl !== 4'b0001) begin n_fail++; $display("FAIL lu_alucontrol got=%h exp=1", ALUControl); end
        tick();
        idle_fwd();
        // Load targeting rt while the immediate is used: no hazard.
        drive_instr(32'hA, 32'h3, 32'h8, 5'd1, 5'd4, 5'd6, 4'b0000, 1'b1, 1'b1);
        tick();
        in_valid        = 1'b0;
        exmem_reg_write = 1'b1;
        exmem_mem_read  = 1'b1;
        exmem_rd_addr   = 5'd4;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_imm_exempt got=%0b exp=1", out_valid); end
        n_checks++; if (data2 !== 32'h8) begin n_fail++; $display("FAIL lu_imm_data2 got=%h exp=8", data2); end
        tick();
        idle_fwd();
        n_checks++; if (bubble_count !== 8'd1) begin n_fail++; $display("FAIL lu_bubble_hold got=%0d exp=1", bubble_count); end
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        drive_instr(32'h100, 32'h200, 32'h0, 5'd7, 5'd8, 5'd9, 4'b0010, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d] got=%0b exp=1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", i, in_ready); end
            n_checks++; if (data1 !== 32'h100 || data2 !== 32'h200) begin n_fail++; $display("FAIL stall_data[%0d] got=%h/%h exp=100/200", i, data1, data2); end
            n_checks++; if (ALUControl !== 4'b0010 || out_rd_addr !== 5'd9) begin n_fail++; $display("FAIL stall_ctrl[%0d] got=%h/%0d exp=2/9", i, ALUControl, out_rd_addr); end
            tick();
        end
        // A retiring MEM/WB writer of rs must leave its value behind.
        memwb_reg_write = 1'b1;
        memwb_rd_addr   = 5'd7;
        memwb_data      = 32'h99;
        tick();
        idle_fwd();
        #1;
        n_checks++; if (data1 !== 32'h99) begin n_fail++; $display("FAIL refresh_data1 got=%h exp=99", data1); end
        n_checks++; if (data2 !== 32'h200) begin n_fail++; $display("FAIL refresh_data2 got=%h exp=200", data2); end
        flush = 1'b1;
        drive_instr(32'hDEAD, 32'hBEEF, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0001, 1'b0, 1'b1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_reg_write got=%0b exp=0", out_reg_write); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL flush_state got=%0b exp=0", dbg_state); end
        n_checks++; if (bubble_count !== 8'd1) begin n_fail++; $display("FAIL flush_bubble got=%0d exp=1", bubble_count); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_instr(32'd11, 32'd12, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b1 || data1 !== 32'd11) begin n_fail++; $display("FAIL b2b_first got=%0b/%0d exp=1/11", out_valid, data1); end
        drive_instr(32'd22, 32'd23, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0001, 1'b0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (data1 !== 32'd22 || ALUControl !== 4'b0001) begin n_fail++; $display("FAIL b2b_second got=%0d/%h exp=22/1", data1, ALUControl); end
        n_checks++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL b2b_reg_write got=%0b exp=0", out_reg_write); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_saturation_and_reset();
        out_ready = 1'b1;
        drive_instr(32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd7, 4'b0010, 1'b0, 1'b1);
        tick();
        in_valid        = 1'b0;
        exmem_reg_write = 1'b1;
        exmem_mem_read  = 1'b1;
        exmem_rd_addr   = 5'd5;
        repeat (300) tick();
        n_checks++; if (bubble_count !== 8'd255) begin n_fail++; $display("FAIL sat_bubble got=%0d exp=255", bubble_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_out_valid got=%0b exp=0", out_valid); end
        // Reset during the stall discards the held instruction.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (bubble_count !== 8'd0) begin n_fail++; $display("FAIL rst_stall_bubble got=%0d exp=0", bubble_count); end
        n_checks++; if (out_valid !== 1'b0 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_stall_state got=%0b/%0b exp=0/0", out_valid, dbg_state); end
        n_checks++; if (ALUControl !== 4'h0 || out_rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_stall_fields got=%h/%0d exp=0/0", ALUControl, out_rd_addr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_in_ready got=%0b exp=1", in_ready); end
        idle_fwd();
    endtask

`ifdef ILLEGAL_OP_TRAP_EN
    task automatic test_illegal_op();
        out_ready = 1'b1;
        drive_instr(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0111, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_set got=%0b exp=1", illegal_op); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_bubble got=%0b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_in_ready got=%0b exp=1", in_ready); end
        drive_instr(32'h4, 32'h5, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || data1 !== 32'h4) begin n_fail++; $display("FAIL ill_next_legal got=%0b/%h exp=1/4", out_valid, data1); end
        n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got=%0b exp=1", illegal_op); end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_reset got=%0b exp=0", illegal_op); end
    endtask
`endif

    // ---------------- main sequence + report ----------------
    initial begin
        reset        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_rs_data   = '0;
        in_rt_data   = '0;
        in_imm       = '0;
        in_rs_addr   = '0;
        in_rt_addr   = '0;
        in_rd_addr   = '0;
        in_alu_op    = '0;
        in_use_imm   = 1'b0;
        in_reg_write = 1'b0;
        out_ready    = 1'b0;
        idle_fwd();

        test_reset();
        test_capture();
        test_forward_priority();
        test_reg0();
        test_load_use();
        test_stall_flush();
        test_back_to_back();
`ifdef ILLEGAL_OP_TRAP_EN
        test_illegal_op();
`endif
        test_saturation_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
